result_writeback_arbiter: RTL
=============================

Name: result_writeback_arbiter

Overview:
- Sequences the MU's four per-pass results into the single-port result SRAM, one word per cycle, at auto-incrementing addresses.
- Shares that same SRAM port with a host readback requester.
- Raises finish once a programmed number of batches has been stored.
- Sits between the MU (arithmetic_finish, result_1..4) and sram_wrapper_wrapper.

Parameters:
DATA_W, 18, result/SRAM word width
ADDR_W, 8, SRAM address width
NUM_BATCHES, 4, batches (4 words each) to write before finish
BASE_ADDR, 0, first write address

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high
arithmetic_finish  in  1  one-cycle pulse; result_1..4 valid this cycle
result_1..result_4  in  DATA_W each  MU results, written in order 1,2,3,4
batch_ready  out  1  high when staging buffer is empty and finish is low
rd_req  in  1  host read request, held until rd_grant
rd_addr  in  ADDR_W  read address, stable while rd_req is high
rd_grant  out  1  one-cycle pulse: read issued to SRAM
rd_data  out  DATA_W  read data, registered
rd_valid  out  1  one-cycle pulse: rd_data valid
ram_web  out  1  SRAM write enable, active-low
ram_addr  out  ADDR_W  SRAM address
ram_wdata  out  DATA_W  SRAM write data
ram_rdata  in  DATA_W  SRAM read data, 1-cycle latency
finish  out  1  sticky: all NUM_BATCHES*4 words written
overflow  out  1  sticky: batch arrived while batch_ready was low

Behaviour:
- Reset (async, active-high) values:
  - state=IDLE; wr_ptr=BASE_ADDR; word count=0; staging buffer empty.
  - last_grant=READ, so a write wins the first tie.
  - ram_web=1, ram_addr=0, ram_wdata=0.
  - rd_grant=0, rd_valid=0, rd_data=0, finish=0, overflow=0, batch_ready=1 (after reset is released).
- Reset mid-operation: an in-flight write/read is abandoned, no partial state survives, and ram_web is 1 immediately.
- Capture:
  - arithmetic_finish with batch_ready=1 latches all four results into the staging buffer and marks a write pending.
  - batch_ready drops the next cycle.
  - arithmetic_finish with batch_ready=0 drops the batch and sets overflow.
- FSM states: IDLE, WRITE, READ, READ_WAIT.
- IDLE:
  - Write pending only -> WRITE.
  - rd_req only -> READ.
  - Both -> grant the side opposite last_grant; update last_grant.
  - Neither -> stay.
- WRITE:
  - Four consecutive cycles, index k=0..3.
  - Each cycle: ram_web=0, ram_addr=wr_ptr, ram_wdata=result_(k+1); wr_ptr increments.
  - wr_ptr wraps from 2^ADDR_W-1 to 0.
  - The batch is atomic: rd_req is not granted mid-batch.
  - After k=3: buffer empties and state -> IDLE.
  - batch_ready rises the cycle after the last write, unless finish is high.
- Write latency: IDLE with write pending at cycle T -> writes at T+1..T+4.
- READ, cycle T:
  - ram_web=1, ram_addr=rd_addr, rd_grant=1; next state READ_WAIT.
  - READ_WAIT at T+1: rd_data<=ram_rdata.
  - rd_valid=1 at T+2, state IDLE at T+2.
- Outside WRITE, ram_web=1; ram_addr/ram_wdata hold their last values.
- finish:
  - Set in the same cycle the NUM_BATCHES*4-th word write completes.
  - Once set, batch_ready stays 0 and later batches set overflow.
  - Reads continue to be served after finish.
- Simultaneous events:
  - arithmetic_finish during the final WRITE cycle counts as overflow, because batch_ready is still 0.
  - rd_req rising during WRITE waits; it is granted the cycle after WRITE ends only if round-robin selects it.

Optional Feature:
- Macro WB_STRICT_WRITE_PRIORITY_EN.
  - Defined: in IDLE a pending write always beats rd_req, and last_grant is ignored; reads may starve while batches keep arriving.
  - Undefined: round-robin as specified in Behaviour.

Decomposition:
- Package wb_arb_pkg:
  - state enum (IDLE, WRITE, READ, READ_WAIT)
  - grant_e (GRANT_WRITE, GRANT_READ)
  - localparam RESULTS_PER_BATCH=4
- One sub-module: wb_stage_buf.
  - Holds the 4-word staging register, full flag and word index.
  - Exposes load, pop and word-out.
- The arbiter FSM stays in the top module.

Test Plan:
- Reset, then one arithmetic_finish with results 0x00011/0x00022/0x00033/0x00044 -> ram_web low for 4 cycles at addr 0..3 with those data; batch_ready high again after the last write.
- 4 batches -> finish rises with the 16th write (addr 15) and stays high; a 5th arithmetic_finish -> no write, overflow=1.
- arithmetic_finish and rd_req(addr 2) in the same idle cycle after reset -> write batch first, then rd_grant; rd_valid 2 cycles after rd_grant with rd_data equal to the word stored at addr 2. With WB_STRICT_WRITE_PRIORITY_EN, continuous batches keep rd_grant low.
- BASE_ADDR=254, one batch -> writes at 254, 255, 0, 1 (wrap).
- Second arithmetic_finish during WRITE cycle k=1 -> dropped, overflow=1, remaining writes unaffected.
- Assert reset during WRITE k=2 -> ram_web=1 immediately, all outputs at reset values; the next batch is written from BASE_ADDR.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the result writeback arbiter.
package wb_arb_pkg;

  localparam int RESULTS_PER_BATCH = 4;
  localparam int IDX_W             = $clog2(RESULTS_PER_BATCH);

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE      = 2'd0;
  localparam state_t ST_WRITE     = 2'd1;
  localparam state_t ST_READ      = 2'd2;
  localparam state_t ST_READ_WAIT = 2'd3;

  typedef enum logic {
    GRANT_WRITE = 1'b0,
    GRANT_READ  = 1'b1
  } grant_e;

endpackage

// File: rtl/wb_stage_buf.sv
// Four-word staging buffer: loads a whole batch at once and pops it one word at a time.
module wb_stage_buf
  import wb_arb_pkg::*;
#(
  parameter int DATA_W = 18
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      load,
  input  logic                                      pop,
  input  logic [RESULTS_PER_BATCH-1:0][DATA_W-1:0]  din,
  output logic                                      full,
  output logic                                      last,
  output logic [DATA_W-1:0]                         word_out
);

  logic [RESULTS_PER_BATCH-1:0][DATA_W-1:0] words_q, words_d;
  logic                                     full_q, full_d;
  logic [IDX_W-1:0]                         idx_q, idx_d;

  always_comb begin
    words_d = words_q;
    full_d  = full_q;
    idx_d   = idx_q;
    if (load) begin
      words_d = din;
      full_d  = 1'b1;
      idx_d   = '0;
    end else if (pop && full_q) begin
      // Popping the last word empties the buffer and rewinds the index.
      if (idx_q == IDX_W'(RESULTS_PER_BATCH - 1)) begin
        full_d = 1'b0;
        idx_d  = '0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      words_q <= '0;
      full_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      words_q <= words_d;
      full_q  <= full_d;
      idx_q   <= idx_d;
    end
  end

  assign full     = full_q;
  assign last     = full_q && (idx_q == IDX_W'(RESULTS_PER_BATCH - 1));
  assign word_out = words_q[idx_q];

endmodule

// File: rtl/result_writeback_arbiter.sv
// Writes MU result batches into the shared single-port SRAM and serves host reads.
// Define WB_STRICT_WRITE_PRIORITY_EN to make pending writes always beat reads.
module result_writeback_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DATA_W      = 18,
  parameter int ADDR_W      = 8,
  parameter int NUM_BATCHES = 4,
  parameter int BASE_ADDR   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              arithmetic_finish,
  input  logic [DATA_W-1:0] result_1,
  input  logic [DATA_W-1:0] result_2,
  input  logic [DATA_W-1:0] result_3,
  input  logic [DATA_W-1:0] result_4,
  output logic              batch_ready,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_grant,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              ram_web,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              finish,
  output logic              overflow
);

  localparam int TOTAL_WORDS = NUM_BATCHES * RESULTS_PER_BATCH;
  localparam int CNT_W       = $clog2(TOTAL_WORDS + 1);

  state_t            state_q, state_d;
  grant_e            last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              finish_q, finish_d;
  logic              overflow_q, overflow_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic [ADDR_W-1:0] addr_hold_q, addr_hold_d;
  logic [DATA_W-1:0] wdata_hold_q, wdata_hold_d;

  logic              buf_full, buf_last, buf_load, buf_pop;
  logic [DATA_W-1:0] buf_word;
  logic              write_pending, write_wins;

  wb_stage_buf #(.DATA_W(DATA_W)) u_stage_buf (
    .clk      (clk),
    .rst      (reset),
    .load     (buf_load),
    .pop      (buf_pop),
    .din      ({result_4, result_3, result_2, result_1}),
    .full     (buf_full),
    .last     (buf_last),
    .word_out (buf_word)
  );

  assign batch_ready = !buf_full && !finish_q;
  assign buf_load    = arithmetic_finish && batch_ready;
  // A batch accepted this cycle already counts as pending for arbitration.
  assign write_pending = buf_full || buf_load;

`ifdef WB_STRICT_WRITE_PRIORITY_EN
  assign write_wins = write_pending;
`else
  assign write_wins = write_pending && (!rd_req || last_grant_q == GRANT_READ);
`endif

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    wr_ptr_d     = wr_ptr_q;
    cnt_d        = cnt_q;
    finish_d     = finish_q;
    overflow_d   = overflow_q;
    rd_data_d    = rd_data_q;
    rd_valid_d   = 1'b0;
    addr_hold_d  = addr_hold_q;
    wdata_hold_d = wdata_hold_q;
    buf_pop      = 1'b0;

    if (arithmetic_finish && !batch_ready) overflow_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (write_wins) begin
          state_d      = ST_WRITE;
          last_grant_d = GRANT_WRITE;
        end else if (rd_req) begin
          state_d      = ST_READ;
          last_grant_d = GRANT_READ;
        end
      end
      ST_WRITE: begin
        buf_pop      = 1'b1;
        wr_ptr_d     = wr_ptr_q + ADDR_W'(1);
        addr_hold_d  = wr_ptr_q;
        wdata_hold_d = buf_word;
        cnt_d        = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(TOTAL_WORDS - 1)) finish_d = 1'b1;
        if (buf_last) state_d = ST_IDLE;
      end
      ST_READ: begin
        addr_hold_d = rd_addr;
        state_d     = ST_READ_WAIT;
      end
      ST_READ_WAIT: begin
        rd_data_d  = ram_rdata;
        rd_valid_d = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GRANT_READ;
      wr_ptr_q     <= ADDR_W'(BASE_ADDR);
      cnt_q        <= '0;
      finish_q     <= 1'b0;
      overflow_q   <= 1'b0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      addr_hold_q  <= '0;
      wdata_hold_q <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      wr_ptr_q     <= wr_ptr_d;
      cnt_q        <= cnt_d;
      finish_q     <= finish_d;
      overflow_q   <= overflow_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
      addr_hold_q  <= addr_hold_d;
      wdata_hold_q <= wdata_hold_d;
    end
  end

  // SRAM strobes follow the state directly so a reset drops ram_web at once.
  assign ram_web   = (state_q != ST_WRITE);
  assign ram_addr  = (state_q == ST_WRITE) ? wr_ptr_q :
                     (state_q == ST_READ)  ? rd_addr  : addr_hold_q;
  assign ram_wdata = (state_q == ST_WRITE) ? buf_word : wdata_hold_q;
  assign rd_grant  = (state_q == ST_READ);
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign finish    = finish_q;
  assign overflow  = overflow_q;

endmodule
